// File: rtl/boot_pkg.sv
// Shared frame constants, field widths and FSM state encoding for the UART boot loader.
package boot_pkg;

  localparam int unsigned LEN_W  = 16;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned WORD_W = 32;

  localparam logic [BYTE_W-1:0] BOOT_SYNC = 8'hA5;
  localparam logic [BYTE_W-1:0] BOOT_ACK  = 8'h4B;
  localparam logic [BYTE_W-1:0] BOOT_NAK  = 8'h45;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN0,
    ST_LEN1,
    ST_DATA,
    ST_CSUM,
    ST_RESP,
    ST_RUN
  } boot_state_e;

endpackage

// File: rtl/boot_word_assembler.sv
// Packs bytes LS-first into 32-bit words and keeps a running XOR of every byte taken.
// word_vld_o pulses the cycle after the 4th byte; no backpressure, one byte per enable.
module boot_word_assembler
  import boot_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clr_i,
  input  logic              en_i,
  input  logic [BYTE_W-1:0] byte_i,
  output logic [WORD_W-1:0] word_o,
  output logic              word_vld_o,
  output logic [BYTE_W-1:0] csum_o
);

  logic [1:0]        lane_q, lane_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic [BYTE_W-1:0] csum_q, csum_d;
  logic              vld_q, vld_d;

  always_comb begin
    lane_d = lane_q;
    word_d = word_q;
    csum_d = csum_q;
    vld_d  = 1'b0;
    if (clr_i) begin
      lane_d = '0;
      word_d = '0;
      csum_d = '0;
    end else if (en_i) begin
      word_d[{lane_q, 3'b000} +: BYTE_W] = byte_i;
      csum_d = csum_q ^ byte_i;
      lane_d = lane_q + 2'd1;
      vld_d  = (lane_q == 2'd3);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lane_q <= '0;
      word_q <= '0;
      csum_q <= '0;
      vld_q  <= 1'b0;
    end else begin
      lane_q <= lane_d;
      word_q <= word_d;
      csum_q <= csum_d;
      vld_q  <= vld_d;
    end
  end

  assign word_o     = word_q;
  assign word_vld_o = vld_q;
  assign csum_o     = csum_q;

endmodule

// File: rtl/uart_boot_sequencer.sv
// Receives a SYNC/LEN/DATA/CSUM frame over UART, loads instruction memory, answers ACK/NAK, then frees the CPU.
// Memory write lands 1 cycle after a word's last byte; the status byte is held until tx_ready.
module uart_boot_sequencer
  import boot_pkg::*;
#(
  parameter int unsigned       ADDR_W    = 10,
  parameter int unsigned       TIMEOUT   = 100000,
  parameter logic [BYTE_W-1:0] SYNC_BYTE = BOOT_SYNC,
  parameter logic [BYTE_W-1:0] ACK_BYTE  = BOOT_ACK,
  parameter logic [BYTE_W-1:0] NAK_BYTE  = BOOT_NAK
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [BYTE_W-1:0] rx_data,
  input  logic              rx_valid,
  output logic [BYTE_W-1:0] tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  output logic              cpu_run,
  output logic              boot_err
);

  localparam int unsigned    TMO_W     = $clog2(TIMEOUT + 1);
  localparam logic [LEN_W:0] MAX_WORDS = (LEN_W + 1)'(2 ** ADDR_W);

  boot_state_e       state_q, state_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  word_cnt_q, word_cnt_d;
  logic [LEN_W-1:0]  len_full;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic [BYTE_W-1:0] tx_data_q, tx_data_d;
  logic              tx_valid_q, tx_valid_d;
  logic              cpu_run_q, cpu_run_d;
  logic              boot_err_q, boot_err_d;
  logic              in_frame, timed_out;
  logic              asm_clr, asm_en, word_vld;
  logic [WORD_W-1:0] word;
  logic [BYTE_W-1:0] csum;

  boot_word_assembler u_asm (
    .clk_i      (CLK),
    .rst_ni     (RST),
    .clr_i      (asm_clr),
    .en_i       (asm_en),
    .byte_i     (rx_data),
    .word_o     (word),
    .word_vld_o (word_vld),
    .csum_o     (csum)
  );

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    word_cnt_d = word_cnt_q;
    tmo_d      = tmo_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    cpu_run_d  = cpu_run_q;
    boot_err_d = boot_err_q;
    asm_clr    = 1'b0;
    asm_en     = 1'b0;
    timed_out  = 1'b0;
    len_full   = {rx_data, len_q[BYTE_W-1:0]};
    in_frame   = (state_q == ST_LEN0) || (state_q == ST_LEN1) ||
                 (state_q == ST_DATA) || (state_q == ST_CSUM);

    // A byte in the expiry cycle wins over the timeout.
    if (!in_frame || rx_valid) begin
      tmo_d = '0;
    end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
      timed_out = 1'b1;
    end else begin
      tmo_d = tmo_q + TMO_W'(1);
    end

    unique case (state_q)
      ST_IDLE: begin
        asm_clr    = 1'b1;
        word_cnt_d = '0;
        if (rx_valid && rx_data == SYNC_BYTE) state_d = ST_LEN0;
      end
      ST_LEN0: begin
        if (rx_valid) begin
          len_d   = {len_q[LEN_W-1:BYTE_W], rx_data};
          state_d = ST_LEN1;
        end
      end
      ST_LEN1: begin
        if (rx_valid) begin
          len_d = len_full;
          if ({1'b0, len_full} > MAX_WORDS) begin
            tx_data_d  = NAK_BYTE;
            tx_valid_d = 1'b1;
            boot_err_d = 1'b1;
            state_d    = ST_RESP;
          end else if (len_full == '0) begin
            state_d = ST_CSUM;
          end else begin
            state_d = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        asm_en = rx_valid;
        // Stay in DATA through the write cycle so mem_we never leaks into CSUM.
        if (word_vld) begin
          word_cnt_d = word_cnt_q + LEN_W'(1);
          if (word_cnt_q == len_q - LEN_W'(1)) state_d = ST_CSUM;
        end
      end
      ST_CSUM: begin
        if (rx_valid) begin
          tx_valid_d = 1'b1;
          state_d    = ST_RESP;
          if (rx_data == csum) begin
            tx_data_d  = ACK_BYTE;
            boot_err_d = 1'b0;
          end else begin
            tx_data_d  = NAK_BYTE;
            boot_err_d = 1'b1;
          end
        end
      end
      ST_RESP: begin
        if (tx_ready) begin
          tx_valid_d = 1'b0;
          if (tx_data_q == ACK_BYTE) begin
            cpu_run_d = 1'b1;
            state_d   = ST_RUN;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_RUN: begin
        cpu_run_d = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase

    if (timed_out) begin
      tx_data_d  = NAK_BYTE;
      tx_valid_d = 1'b1;
      boot_err_d = 1'b1;
      state_d    = ST_RESP;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= ST_IDLE;
      len_q      <= '0;
      word_cnt_q <= '0;
      tmo_q      <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      cpu_run_q  <= 1'b0;
      boot_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      word_cnt_q <= word_cnt_d;
      tmo_q      <= tmo_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      cpu_run_q  <= cpu_run_d;
      boot_err_q <= boot_err_d;
    end
  end

  assign tx_data   = tx_data_q;
  assign tx_valid  = tx_valid_q;
  assign mem_we    = word_vld;
  assign mem_addr  = word_cnt_q[ADDR_W-1:0];
  assign mem_wdata = word;
  assign cpu_run   = cpu_run_q;
  assign boot_err  = boot_err_q;

endmodule

// File: tb/tb_uart_boot_sequencer.sv
// Self-checking bench: directed boundary frames plus random frames against a frame-level reference model.
module tb_uart_boot_sequencer;

  localparam int AW  = 4;
  localparam int TMO = 50;
  localparam logic [7:0] ACK = 8'h4B;
  localparam logic [7:0] NAK = 8'h45;

  typedef logic [7:0]  bq_t[$];
  typedef logic [31:0] wq_t[$];

  logic          CLK      = 1'b0;
  logic          RST      = 1'b0;
  logic [7:0]    rx_data  = 8'h00;
  logic          rx_valid = 1'b0;
  logic          tx_ready = 1'b1;
  logic [7:0]    tx_data;
  logic          tx_valid;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          cpu_run;
  logic          boot_err;

  int n_checks = 0;
  int n_errs   = 0;
  int cyc = 0, hs_cyc = 0, txv_cyc = 0, run_cyc = 0, last_strobe = 0;
  logic txv_prev = 1'b0, run_prev = 1'b0;
  logic [AW+31:0] wr_q[$];
  logic [7:0]     tx_q[$];

  uart_boot_sequencer #(.ADDR_W(AW), .TIMEOUT(TMO)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .cpu_run   (cpu_run),
    .boot_err  (boot_err)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  always @(negedge CLK) begin
    if (mem_we) wr_q.push_back({mem_addr, mem_wdata});
    if (tx_valid && tx_ready) begin
      tx_q.push_back(tx_data);
      hs_cyc = cyc;
    end
    if (tx_valid && !txv_prev) txv_cyc = cyc;
    if (cpu_run && !run_prev) run_cyc = cyc;
    txv_prev = tx_valid;
    run_prev = cpu_run;
  end

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    rx_data     = b;
    rx_valid    = 1'b1;
    last_strobe = cyc;
    tick(1);
    rx_valid = 1'b0;
    tick(gap);
  endtask

  task automatic do_reset();
    RST      = 1'b0;
    rx_valid = 1'b0;
    tx_ready = 1'b1;
    tick(3);
    RST = 1'b1;
    tick(2);
  endtask

  // Reference model: frame bytes, expected writes and expected status from the frame rules alone.
  task automatic build_frame(input int n, input wq_t words, input int csum_force,
                             output bq_t fb, output wq_t ew, output logic [7:0] et);
    logic [7:0]  x, b, c;
    logic [31:0] w;
    fb.delete();
    ew.delete();
    x = 8'h00;
    fb.push_back(8'hA5);
    fb.push_back(n[7:0]);
    fb.push_back(n[15:8]);
    if (n > (1 << AW)) begin
      et = NAK;
    end else begin
      for (int i = 0; i < n; i++) begin
        w = words[i];
        ew.push_back(w);
        for (int k = 0; k < 4; k++) begin
          b = w[8*k +: 8];
          fb.push_back(b);
          x = x ^ b;
        end
      end
      c = (csum_force < 0) ? x : csum_force[7:0];
      fb.push_back(c);
      et = (c == x) ? ACK : NAK;
    end
  endtask

  task automatic run_frame(input string tag, input bq_t fb, input int gap, input int hold,
                           input wq_t ew, input logic [7:0] et);
    logic stable;
    logic [AW+31:0] exp_wr;
    wr_q.delete();
    tx_q.delete();
    tx_ready = (hold == 0);
    foreach (fb[i]) send_byte(fb[i], gap);
    for (int i = 0; i < 500 && !tx_valid && tx_q.size() == 0; i++) tick(1);
    if (hold > 0) begin
      stable = 1'b1;
      repeat (hold) begin
        @(negedge CLK);
        if (!(tx_valid === 1'b1 && tx_data === et)) stable = 1'b0;
      end
      chk_eq({tag, ":bp_stable"}, stable, 1);
      chk_eq({tag, ":bp_no_hs"}, tx_q.size(), 0);
      @(posedge CLK);
      #1;
      tx_ready = 1'b1;
    end
    for (int i = 0; i < 50 && tx_q.size() == 0; i++) tick(1);
    tick(3);
    chk_eq({tag, ":n_wr"}, wr_q.size(), ew.size());
    foreach (ew[i]) begin
      exp_wr = {i[AW-1:0], ew[i]};
      if (i < wr_q.size()) chk_eq($sformatf("%s:wr%0d", tag, i), wr_q[i], exp_wr);
    end
    chk_eq({tag, ":n_tx"}, tx_q.size(), 1);
    if (tx_q.size() > 0) chk_eq({tag, ":tx"}, tx_q[0], et);
    chk_eq({tag, ":err"}, boot_err, (et != ACK));
    chk_eq({tag, ":run"}, cpu_run, (et == ACK));
    if (et == ACK) chk_eq({tag, ":run_lat"}, run_cyc - hs_cyc, 1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d checks %0d errors", n_checks, n_errs);
    $fatal(1);
  end

  initial begin
    bq_t fb;
    wq_t w, ew;
    logic [7:0] et;
    int n, cf;

    tick(2);
    chk_eq("reset_outs", {tx_data, tx_valid, mem_we, mem_addr, mem_wdata, cpu_run, boot_err}, 0);
    RST = 1'b1;
    tick(2);
    chk_eq("idle_outs", {tx_data, tx_valid, mem_we, mem_addr, mem_wdata, cpu_run, boot_err}, 0);

    w.delete();
    w.push_back(32'h00000013);
    w.push_back(32'h00100093);
    build_frame(2, w, -1, fb, ew, et);
    run_frame("good", fb, 2, 0, ew, et);
    do_reset();

    build_frame(2, w, 0, fb, ew, et);
    run_frame("bad", fb, 2, 0, ew, et);
    build_frame(2, w, -1, fb, ew, et);
    run_frame("retry", fb, 3, 0, ew, et);
    do_reset();

    build_frame(17, w, -1, fb, ew, et);
    run_frame("ovs", fb, 1, 0, ew, et);
    chk_eq("ovs_lat", txv_cyc - last_strobe, 1);

    fb.delete();
    ew.delete();
    fb.push_back(8'hA5);
    fb.push_back(8'h01);
    fb.push_back(8'h00);
    fb.push_back(8'hAA);
    run_frame("tmo", fb, 1, 0, ew, NAK);
    chk_eq("tmo_lat", txv_cyc - last_strobe, TMO + 1);

    wr_q.delete();
    send_byte(8'hA5, 1);
    send_byte(8'h01, 1);
    send_byte(8'h00, 1);
    send_byte(8'h11, 1);
    send_byte(8'h22, 1);
    #2;
    RST = 1'b0;
    #1;
    chk_eq("rst_async", {tx_data, tx_valid, mem_we, mem_addr, mem_wdata, cpu_run, boot_err}, 0);
    tick(2);
    chk_eq("rst_no_we", wr_q.size(), 0);
    RST = 1'b1;
    tick(2);
    w.delete();
    for (int i = 0; i < 3; i++) w.push_back($urandom);
    build_frame(3, w, -1, fb, ew, et);
    run_frame("post_rst", fb, 1, 0, ew, et);
    do_reset();

    w.delete();
    build_frame(0, w, -1, fb, ew, et);
    run_frame("zero", fb, 2, 0, ew, et);
    do_reset();

    w.push_back(32'hDDCCBBAA);
    build_frame(1, w, -1, fb, ew, et);
    run_frame("late", fb, TMO - 1, 0, ew, et);
    do_reset();

    send_byte(8'h00, 2);
    send_byte(8'hFF, 2);
    w.delete();
    w.push_back($urandom);
    w.push_back($urandom);
    build_frame(2, w, -1, fb, ew, et);
    run_frame("bp", fb, 2, 20, ew, et);
    do_reset();

    for (int it = 0; it < 10; it++) begin
      n = $urandom_range(0, 18);
      w.delete();
      for (int i = 0; i < n; i++) w.push_back($urandom);
      cf = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255)) : -1;
      build_frame(n, w, cf, fb, ew, et);
      run_frame($sformatf("rnd%0d", it), fb, $urandom_range(1, 4),
                ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 8)) : 0, ew, et);
      if (et == ACK) do_reset();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule
